rv32i_decode_stage: RTL and testbench
=====================================

Name: rv32i_decode_stage

Overview:
- Pipelined RV32I decode stage; the producer of every control input the 32-bit ALU consumes (r_type, i_type, b_type, funct3, funct7, op_consShf, sub_sign_extEn) plus the operand selectors and immediate.
- Sits between fetch and execute.
- Valid/ready on both sides, 1-cycle latency, 2-entry skid buffer so in_ready is fully registered.

Parameters:
- XLEN, 32, datapath/instruction width; only 32 supported.
- SKID_DEPTH, 2, buffer entries; fixed at 2 (main + skid).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush (branch taken/trap).
- in_valid  in  1  fetch word valid.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts bundle.
- r_type, i_type, b_type  out  1 each  ALU class selects.
- funct3  out  3  ALU funct3.
- funct7  out  7  ALU funct7.
- op_consShf  out  1  immediate shift; ALU uses funct7[5].
- sub_sign_extEn  out  1  sign-extend operands of the 33-bit subtract.
- br_funct3  out  3  original branch condition for the branch unit.
- rs1, rs2, rd  out  5 each  register indices.
- imm  out  32  decoded immediate.
- pc  out  32  pc of bundle.
- illegal  out  1  unsupported encoding.

Behaviour:
- Reset:
  - out_valid=0, in_ready=1, both entries invalid.
  - All bundle outputs are 0.
- Transfers:
  - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
  - Accepted word appears decoded at out_valid the next cycle when the main entry is empty or is draining.
  - Main entry is held while out_valid & !out_ready. A word arriving then goes to the skid entry.
  - in_ready deasserts the cycle after the skid entry fills. It reasserts the cycle after the skid entry moves to main.
- Ordering and stability:
  - Strict in-order delivery; no drop, no duplicate.
  - Bundle outputs are stable while out_valid & !out_ready.
- Flush:
  - Both entries are invalidated at the clock edge where flush=1.
  - An input accepted in the same cycle is discarded.
  - out_valid=0 and in_ready=1 the next cycle. Flush has priority over all handshakes.
- Decoding by opcode[6:0]:
  - 0110011 OP: r_type=1; funct3/funct7 are passed through. Legal funct7 is 0000000, or 0100000 only with funct3 000/101. sub_sign_extEn=0.
  - 0010011 OP-IMM: i_type=1. funct3 001/101 set op_consShf=1; funct7 is passed through and must be 0000000 (001) or 0000000/0100000 (101); imm={27'b0,shamt}. Other funct3: funct7=0, imm = sign-extended I-imm.
  - 0000011 LOAD, 1100111 JALR: i_type=1, funct3=000, funct7=0 (ADD), I-imm. JALR requires funct3=000.
  - 0100011 STORE: all ALU selects 0, funct3=000, funct7=0 (ADD), S-imm.
  - 1100011 BRANCH:
    - b_type=1, funct3=000, funct7=0100000 (SUB).
    - br_funct3=instr[14:12]; sub_sign_extEn=1 for 100/101 (BLT/BGE), else 0. funct3 010/011 are illegal.
    - The ALU flag is the borrow/sign bit of the 33-bit difference.
    - imm = B-imm, sign-extended, bit0=0.
  - 0110111 LUI / 0010111 AUIPC: ADD encoding, imm={instr[31:12],12'b0}.
  - 1101111 JAL: ADD encoding, J-imm.
  - Unused fields are forced to 0: rs2 for I/U/J, rd for S/B, rs1 for U/J. br_funct3=0 for non-branches.
- Illegal: any other opcode or a rule violation above sets illegal=1. ALU selects, funct3 and funct7 become 0 (ADD), imm=0. Registers and pc are passed through.
- Reset mid-operation: immediate clear to the reset state regardless of clk. Nothing already in the buffer is emitted after release.

Test Plan:
- Reset release, then in_instr=0x002081B3 (add x3,x1,x2), out_ready=1 → next cycle out_valid=1, r_type=1, funct3=000, funct7=0, rs1=1, rs2=2, rd=3, illegal=0.
- 0x407302B3 (sub x5,x6,x7) → r_type=1, funct7=0100000, sub_sign_extEn=0. Then 0x40315093 (srai x1,x2,3) → i_type=1, op_consShf=1, funct7=0100000, imm=0x00000003.
- 0x0020C463 (blt x1,x2,+8) → b_type=1, funct3=000, funct7=0100000, sub_sign_extEn=1, br_funct3=100, imm=0x00000008, rd=0. The same branch with funct3=110 gives sub_sign_extEn=0.
- out_ready=0 while 3 words stream (A,B,C) → A held stable; B goes to skid; in_ready=0 the cycle after B is accepted; C waits. out_ready=1 → A,B,C emerge in order, one per cycle.
- flush while both entries are full and in_valid=1 → next cycle out_valid=0, in_ready=1, and none of the three words ever appears at the output.
- 0xFFFFFFFF → illegal=1, funct3=0, funct7=0, r_type=i_type=b_type=0, imm=0. rst_n low mid-stall → out_valid=0 asynchronously, in_ready=1 after release.

Source files
------------

// File: rtl/rv32i_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_decode_stage
// Purpose  : Pipelined RV32I decode stage between fetch and execute. It turns
//            each fetched word into the ALU control bundle, the operand
//            register indices and the decoded immediate. A two-entry buffer
//            (main + skid) lets in_ready come straight from a flop.
// Ports    : clk, rst_n (async, active low), flush (sync pipeline flush)
//            in_valid / in_ready / in_instr / in_pc   : fetch side
//            out_valid / out_ready                     : execute side
//            r_type, i_type, b_type, funct3, funct7,
//            op_consShf, sub_sign_extEn                : ALU controls
//            br_funct3                                 : branch condition
//            rs1, rs2, rd, imm, pc, illegal            : decoded bundle
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_decode_stage #(
    parameter int XLEN       = 32,
    parameter int SKID_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            r_type,
    output logic            i_type,
    output logic            b_type,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            op_consShf,
    output logic            sub_sign_extEn,
    output logic [2:0]      br_funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc,
    output logic            illegal
);

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_F7_ALT     = 7'b0100000;
    localparam logic [1:0] c_DEPTH      = SKID_DEPTH[1:0];

    typedef struct packed {
        logic            r_type;
        logic            i_type;
        logic            b_type;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            op_cons_shf;
        logic            sub_sext;
        logic [2:0]      br_funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } bundle_t;

    // ------------------------------------------------------------------
    // Instruction field extraction and immediate formats
    // ------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;

    assign w_opcode = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];
    assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u  = {in_instr[31:12], 12'b0};
    assign w_imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Decoder: everything defaults to the ADD encoding with no selects.
    // ------------------------------------------------------------------
    bundle_t w_dec;
    logic    w_bad;

    always_comb begin
        w_dec     = '0;
        w_dec.rs1 = in_instr[19:15];
        w_dec.rs2 = in_instr[24:20];
        w_dec.rd  = in_instr[11:7];
        w_dec.pc  = in_pc;
        w_bad     = 1'b0;

        case (w_opcode)
            c_OPC_OP: begin
                w_dec.r_type = 1'b1;
                w_dec.funct3 = w_f3;
                w_dec.funct7 = w_f7;
                // Only ADD/SUB and SRL/SRA have an alternate funct7.
                w_bad = !((w_f7 == 7'b0) ||
                          ((w_f7 == c_F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
            end
            c_OPC_OPIMM: begin
                w_dec.i_type = 1'b1;
                w_dec.funct3 = w_f3;
                w_dec.rs2    = '0;
                if ((w_f3 == 3'b001) || (w_f3 == 3'b101)) begin
                    // Immediate shifts: funct7 carries the SRA/SRL select.
                    w_dec.op_cons_shf = 1'b1;
                    w_dec.funct7      = w_f7;
                    w_dec.imm         = {27'b0, in_instr[24:20]};
                    if (w_f3 == 3'b001) begin
                        w_bad = (w_f7 != 7'b0);
                    end else begin
                        w_bad = !((w_f7 == 7'b0) || (w_f7 == c_F7_ALT));
                    end
                end else begin
                    w_dec.imm = w_imm_i;
                end
            end
            c_OPC_LOAD: begin
                w_dec.i_type = 1'b1;
                w_dec.rs2    = '0;
                w_dec.imm    = w_imm_i;
            end
            c_OPC_JALR: begin
                w_dec.i_type = 1'b1;
                w_dec.rs2    = '0;
                w_dec.imm    = w_imm_i;
                w_bad        = (w_f3 != 3'b000);
            end
            c_OPC_STORE: begin
                w_dec.rd  = '0;
                w_dec.imm = w_imm_s;
            end
            c_OPC_BRANCH: begin
                // ALU computes rs1-rs2 in 33 bits; the branch unit reads the
                // borrow/sign bit, signed for BLT/BGE only.
                w_dec.b_type    = 1'b1;
                w_dec.funct7    = c_F7_ALT;
                w_dec.br_funct3 = w_f3;
                w_dec.sub_sext  = (w_f3 == 3'b100) || (w_f3 == 3'b101);
                w_dec.rd        = '0;
                w_dec.imm       = w_imm_b;
                w_bad           = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            c_OPC_LUI, c_OPC_AUIPC: begin
                w_dec.rs1 = '0;
                w_dec.rs2 = '0;
                w_dec.imm = w_imm_u;
            end
            c_OPC_JAL: begin
                w_dec.rs1 = '0;
                w_dec.rs2 = '0;
                w_dec.imm = w_imm_j;
            end
            default: begin
                w_bad = 1'b1;
            end
        endcase

        // Illegal words keep raw register fields and pc; controls fall to ADD.
        if (w_bad) begin
            w_dec         = '0;
            w_dec.rs1     = in_instr[19:15];
            w_dec.rs2     = in_instr[24:20];
            w_dec.rd      = in_instr[11:7];
            w_dec.pc      = in_pc;
            w_dec.illegal = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Main + skid buffer
    // ------------------------------------------------------------------
    bundle_t    main_q, main_d, skid_q, skid_d;
    logic       main_valid_q, main_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       in_ready_q, in_ready_d;
    logic       w_in_fire;
    logic [1:0] w_occ_d;

    assign w_in_fire = in_valid & in_ready_q;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_ready) begin
            // Main is free this edge. in_ready is low whenever skid holds a
            // word, so a skid refill and a new input never coincide.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (w_in_fire) begin
                main_d       = w_dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (w_in_fire) begin
            skid_d       = w_dec;
            skid_valid_d = 1'b1;
        end

        w_occ_d    = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
        in_ready_d = (w_occ_d < c_DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready       = in_ready_q;
    assign out_valid      = main_valid_q;
    assign r_type         = main_q.r_type;
    assign i_type         = main_q.i_type;
    assign b_type         = main_q.b_type;
    assign funct3         = main_q.funct3;
    assign funct7         = main_q.funct7;
    assign op_consShf     = main_q.op_cons_shf;
    assign sub_sign_extEn = main_q.sub_sext;
    assign br_funct3      = main_q.br_funct3;
    assign rs1            = main_q.rs1;
    assign rs2            = main_q.rs2;
    assign rd             = main_q.rd;
    assign imm            = main_q.imm;
    assign pc             = main_q.pc;
    assign illegal        = main_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_decode_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rv32i_decode_stage
// Purpose  : Directed self-checking bench for rv32i_decode_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic        r_type, i_type, b_type;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        op_consShf, sub_sign_extEn;
    logic [2:0]  br_funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, pc;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv32i_decode_stage #(.XLEN(32), .SKID_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .r_type(r_type), .i_type(i_type), .b_type(b_type),
        .funct3(funct3), .funct7(funct7),
        .op_consShf(op_consShf), .sub_sign_extEn(sub_sign_extEn),
        .br_funct3(br_funct3), .rs1(rs1), .rs2(rs2), .rd(rd),
        .imm(imm), .pc(pc), .illegal(illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [31:0] instr, input logic [31:0] addr);
        in_valid = 1'b1; in_instr = instr; in_pc = addr;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if ({r_type, i_type, b_type, funct3, funct7, op_consShf, sub_sign_extEn, br_funct3, rs1, rs2, rd, imm, pc, illegal} !== '0) begin
            failures++; $display("FAIL reset_bundle got imm=%h pc=%h rd=%0d exp all zero", imm, pc, rd); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        send_one(32'h002081B3, 32'h100);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        checks++; if ({r_type, i_type, b_type} !== 3'b100) begin failures++; $display("FAIL add_sel got=%b exp=100", {r_type, i_type, b_type}); end
        checks++; if ({funct3, funct7} !== 10'b0) begin failures++; $display("FAIL add_funct got=%b exp=0", {funct3, funct7}); end
        checks++; if ({rs1, rs2, rd} !== {5'd1, 5'd2, 5'd3}) begin failures++; $display("FAIL add_regs got=%0d,%0d,%0d exp=1,2,3", rs1, rs2, rd); end
        checks++; if ({illegal, op_consShf, sub_sign_extEn, br_funct3} !== 6'b0) begin failures++; $display("FAIL add_flags got=%b exp=0", {illegal, op_consShf, sub_sign_extEn, br_funct3}); end
        checks++; if (pc !== 32'h100) begin failures++; $display("FAIL add_pc got=%h exp=100", pc); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_sub_srai();
        in_valid = 1'b1; in_instr = 32'h407302B3; in_pc = 32'h104;
        step();
        in_instr = 32'h40315093; in_pc = 32'h108;
        checks++; if ({r_type, i_type, b_type} !== 3'b100) begin failures++; $display("FAIL sub_sel got=%b exp=100", {r_type, i_type, b_type}); end
        checks++; if ({funct3, funct7, sub_sign_extEn} !== {3'b000, 7'b0100000, 1'b0}) begin failures++; $display("FAIL sub_funct got=%b exp=000_0100000_0", {funct3, funct7, sub_sign_extEn}); end
        checks++; if ({rs1, rs2, rd} !== {5'd6, 5'd7, 5'd5}) begin failures++; $display("FAIL sub_regs got=%0d,%0d,%0d exp=6,7,5", rs1, rs2, rd); end
        step();
        in_valid = 1'b0;
        checks++; if ({r_type, i_type, b_type, op_consShf} !== 4'b0101) begin failures++; $display("FAIL srai_sel got=%b exp=0101", {r_type, i_type, b_type, op_consShf}); end
        checks++; if ({funct3, funct7} !== {3'b101, 7'b0100000}) begin failures++; $display("FAIL srai_funct got=%b exp=101_0100000", {funct3, funct7}); end
        checks++; if (imm !== 32'h3) begin failures++; $display("FAIL srai_imm got=%h exp=00000003", imm); end
        checks++; if ({rs1, rs2, rd, illegal} !== {5'd2, 5'd0, 5'd1, 1'b0}) begin failures++; $display("FAIL srai_regs got=%0d,%0d,%0d ill=%b exp=2,0,1 ill=0", rs1, rs2, rd, illegal); end
        step();
    endtask

    task automatic test_branch();
        in_valid = 1'b1; in_instr = 32'h0020C463; in_pc = 32'h10C;
        step();
        in_instr = 32'h0020E463; in_pc = 32'h110;
        checks++; if ({r_type, i_type, b_type} !== 3'b001) begin failures++; $display("FAIL blt_sel got=%b exp=001", {r_type, i_type, b_type}); end
        checks++; if ({funct3, funct7} !== {3'b000, 7'b0100000}) begin failures++; $display("FAIL blt_funct got=%b exp=000_0100000", {funct3, funct7}); end
        checks++; if ({sub_sign_extEn, br_funct3} !== 4'b1100) begin failures++; $display("FAIL blt_cond got=%b exp=1100", {sub_sign_extEn, br_funct3}); end
        checks++; if (imm !== 32'h8) begin failures++; $display("FAIL blt_imm got=%h exp=00000008", imm); end
        checks++; if ({rs1, rs2, rd} !== {5'd1, 5'd2, 5'd0}) begin failures++; $display("FAIL blt_regs got=%0d,%0d,%0d exp=1,2,0", rs1, rs2, rd); end
        step();
        in_valid = 1'b0;
        checks++; if ({b_type, sub_sign_extEn, br_funct3, illegal} !== 6'b101100) begin failures++; $display("FAIL bltu_cond got=%b exp=101100", {b_type, sub_sign_extEn, br_funct3, illegal}); end
        step();
    endtask

    task automatic test_imm_forms();
        send_one(32'hFFF00093, 32'h120); // addi x1,x0,-1
        checks++; if ({i_type, funct3, funct7, op_consShf} !== {1'b1, 11'b0}) begin failures++; $display("FAIL addi_ctl got=%b exp=1_0", {i_type, funct3, funct7, op_consShf}); end
        checks++; if ({imm, rs2, rd} !== {32'hFFFFFFFF, 5'd0, 5'd1}) begin failures++; $display("FAIL addi_imm got=%h rs2=%0d rd=%0d exp=ffffffff 0 1", imm, rs2, rd); end
        send_one(32'h0020A423, 32'h124); // sw x2,8(x1)
        checks++; if ({r_type, i_type, b_type, funct3, funct7} !== 13'b0) begin failures++; $display("FAIL sw_ctl got=%b exp=0", {r_type, i_type, b_type, funct3, funct7}); end
        checks++; if ({imm, rs1, rs2, rd} !== {32'h8, 5'd1, 5'd2, 5'd0}) begin failures++; $display("FAIL sw_fields got=%h %0d %0d %0d exp=8 1 2 0", imm, rs1, rs2, rd); end
        send_one(32'h123452B7, 32'h128); // lui x5,0x12345
        checks++; if ({imm, rs1, rs2, rd, funct3, funct7} !== {32'h12345000, 5'd0, 5'd0, 5'd5, 10'b0}) begin failures++; $display("FAIL lui got=%h %0d %0d %0d exp=12345000 0 0 5", imm, rs1, rs2, rd); end
        send_one(32'h010000EF, 32'h12C); // jal x1,+16
        checks++; if ({imm, rs1, rs2, rd, illegal} !== {32'h10, 5'd0, 5'd0, 5'd1, 1'b0}) begin failures++; $display("FAIL jal got=%h %0d %0d %0d ill=%b exp=10 0 0 1 0", imm, rs1, rs2, rd, illegal); end
        step();
    endtask

    task automatic test_illegal();
        send_one(32'hFFFFFFFF, 32'h130);
        checks++; if ({illegal, r_type, i_type, b_type, funct3, funct7} !== {1'b1, 13'b0}) begin failures++; $display("FAIL ill_ctl got=%b exp=1_0", {illegal, r_type, i_type, b_type, funct3, funct7}); end
        checks++; if ({imm, rs1, rs2, rd, pc} !== {32'h0, 5'd31, 5'd31, 5'd31, 32'h130}) begin failures++; $display("FAIL ill_fields got=%h %0d %0d %0d pc=%h exp=0 31 31 31 130", imm, rs1, rs2, rd, pc); end
        send_one(32'h020081B3, 32'h134); // OP with funct7=0000001
        checks++; if ({illegal, r_type, funct7, rd} !== {1'b1, 1'b0, 7'b0, 5'd3}) begin failures++; $display("FAIL ill_f7 got=%b exp=1_0_0_00011", {illegal, r_type, funct7, rd}); end
        send_one(32'h0020A463, 32'h138); // BRANCH funct3=010
        checks++; if ({illegal, b_type, br_funct3, imm} !== {1'b1, 1'b0, 3'b0, 32'h0}) begin failures++; $display("FAIL ill_br got=%b %h exp=1_0_000 0", {illegal, b_type, br_funct3}, imm); end
        send_one(32'h40311093, 32'h13C); // slli with funct7=0100000
        checks++; if ({illegal, i_type, op_consShf} !== 3'b100) begin failures++; $display("FAIL ill_slli got=%b exp=100", {illegal, i_type, op_consShf}); end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h200;   // A
        step();
        checks++; if ({out_valid, in_ready, pc} !== {2'b11, 32'h200}) begin failures++; $display("FAIL bb_a_first got=%b%b %h exp=11 200", out_valid, in_ready, pc); end
        in_instr = 32'h407302B3; in_pc = 32'h204;                    // B
        step();
        checks++; if ({in_ready, pc, rd} !== {1'b0, 32'h200, 5'd3}) begin failures++; $display("FAIL bb_skid_full got=rdy%b %h rd=%0d exp=rdy0 200 3", in_ready, pc, rd); end
        in_instr = 32'hFFF00093; in_pc = 32'h208;                    // C
        step();
        checks++; if ({out_valid, in_ready, pc, funct7} !== {2'b10, 32'h200, 7'b0}) begin failures++; $display("FAIL bb_hold got=%b%b %h exp=10 200", out_valid, in_ready, pc); end
        out_ready = 1'b1;
        step();
        checks++; if ({out_valid, in_ready, pc, funct7} !== {2'b11, 32'h204, 7'b0100000}) begin failures++; $display("FAIL bb_b got=%b%b %h f7=%b exp=11 204 0100000", out_valid, in_ready, pc, funct7); end
        step();
        in_valid = 1'b0;
        checks++; if ({out_valid, pc, imm} !== {1'b1, 32'h208, 32'hFFFFFFFF}) begin failures++; $display("FAIL bb_c got=%b %h %h exp=1 208 ffffffff", out_valid, pc, imm); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bb_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h300;
        step();
        in_pc = 32'h304;
        step();
        in_pc = 32'h308; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL flush_full got=%b%b exp=01", out_valid, in_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_leak cyc=%0d got=%b pc=%h exp=0", k, out_valid, pc); end
        end
        // Input accepted on the flush edge is also discarded.
        out_ready = 1'b0;
        send_one(32'h002081B3, 32'h30C);
        in_valid = 1'b1; in_pc = 32'h310; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL flush_in got=%b%b exp=01", out_valid, in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_in_leak got=%b pc=%h exp=0", out_valid, pc); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h400;
        step();
        in_pc = 32'h404;
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, in_ready, pc} !== {2'b01, 32'h0}) begin failures++; $display("FAIL async_rst got=%b%b %h exp=01 0", out_valid, in_ready, pc); end
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL rst_release cyc=%0d got=%b%b exp=01", k, out_valid, in_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_srai();
        test_branch();
        test_imm_forms();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
